// File: rtl/seg_scan_capture_if.sv
// Bus between a multiplexed 7-segment scanner (master) and the capture monitor (slave).
// Carries the raw anode/segment lines plus the decoded frame results.
interface seg_scan_capture_if;
    logic [3:0] pos;
    logic [6:0] dout;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [3:0] n3;
    logic [3:0] n4;
    logic       frame_stb;
    logic       digit_err;
    logic       lost;

    modport master (
        output pos, dout,
        input  n1, n2, n3, n4, frame_stb, digit_err, lost
    );

    modport slave (
        input  pos, dout,
        output n1, n2, n3, n4, frame_stb, digit_err, lost
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Observes a multiplexed 7-segment scan, decodes each settled digit back to a nibble
// and publishes all four digits together once every digit has been seen.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_LOST    | no complete frame since reset or since the scan timed out
// ST_LOCKED  | at least one frame completed and the scan is still alive
module seg_scan_capture #(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_capture_if.slave bus
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_ACC = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic {
        ST_LOST   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;

    logic [10:0]     sync1_q, sync2_q, prev_q;
    logic [SW-1:0]   settle_q, settle_d;
    logic            acc_q, acc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] nout_q, nout_d;
    logic            stb_q, stb_d;
    logic            err_q, err_d;

    logic [3:0]      pos_s;
    logic [6:0]      dout_s;
    logic            stable;
    logic            pos_ok;
    logic [1:0]      pos_idx;
    logic            pat_ok;
    logic [3:0]      nib;
    logic            accept;
    logic            frame_done;

    assign pos_s  = sync2_q[10:7];
    assign dout_s = sync2_q[6:0];
    assign stable = (sync2_q == prev_q);

    always_comb begin
        pos_ok  = 1'b1;
        pos_idx = 2'd0;
        case (pos_s)
            4'b1110: pos_idx = 2'd0;
            4'b1101: pos_idx = 2'd1;
            4'b1011: pos_idx = 2'd2;
            4'b0111: pos_idx = 2'd3;
            default: pos_ok  = 1'b0;
        endcase
    end

    // Segments are active-low {a,b,c,d,e,f,g}; only exact glyphs decode.
    always_comb begin
        pat_ok = 1'b1;
        nib    = 4'h0;
        case (dout_s)
            7'h01:   nib = 4'h0;
            7'h4F:   nib = 4'h1;
            7'h12:   nib = 4'h2;
            7'h06:   nib = 4'h3;
            7'h4C:   nib = 4'h4;
            7'h24:   nib = 4'h5;
            7'h20:   nib = 4'h6;
            7'h0F:   nib = 4'h7;
            7'h00:   nib = 4'h8;
            7'h04:   nib = 4'h9;
            7'h08:   nib = 4'hA;
            7'h60:   nib = 4'hB;
            7'h31:   nib = 4'hC;
            7'h42:   nib = 4'hD;
            7'h30:   nib = 4'hE;
            7'h38:   nib = 4'hF;
            default: pat_ok = 1'b0;
        endcase
    end

    // One accept per dwell: the flag blocks re-accept until {pos,dout} moves.
    assign accept = stable && (settle_q == SETTLE_ACC) && !acc_q && pos_ok;

    always_comb begin
        settle_d = settle_q;
        acc_d    = acc_q;
        if (!stable) begin
            settle_d = '0;
            acc_d    = 1'b0;
        end else begin
            if (settle_q != SETTLE_MAX) begin
                settle_d = settle_q + SW'(1);
            end
            if (accept) begin
                acc_d = 1'b1;
            end
        end
    end

    assign frame_done = (seen_q == 4'hF);

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        nout_d   = nout_q;
        tmo_d    = tmo_q;
        stb_d    = 1'b0;
        err_d    = 1'b0;

        if (frame_done) begin
            nout_d  = shadow_q;
            stb_d   = 1'b1;
            seen_d  = 4'h0;
            state_d = ST_LOCKED;
        end

        if (accept) begin
            tmo_d = '0;
            if (pat_ok) begin
                shadow_d[pos_idx] = nib;
                seen_d[pos_idx]   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (tmo_q == TMO_LAST) begin
            // Counter parks here; frame completion outranks the timeout.
            if (!frame_done) begin
                state_d = ST_LOST;
                seen_d  = 4'h0;
            end
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            settle_q <= '0;
            acc_q    <= 1'b0;
            tmo_q    <= '0;
            seen_q   <= 4'h0;
            shadow_q <= '0;
            nout_q   <= '0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= ST_LOST;
        end else begin
            sync1_q  <= {bus.pos, bus.dout};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= settle_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            nout_q   <= nout_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    assign bus.n1        = nout_q[0];
    assign bus.n2        = nout_q[1];
    assign bus.n3        = nout_q[2];
    assign bus.n4        = nout_q[3];
    assign bus.frame_stb = stb_q;
    assign bus.digit_err = err_q;
    assign bus.lost      = (state_q == ST_LOST);

endmodule
